led_pattern_sequencer: RTL
==========================

Name: led_pattern_sequencer

Overview:
- Parametrised successor to the single-toggle LED demux top.
- An internal maximal-length LFSR prescaler generates a one-cycle tick every 2^NUM_LFSR_BITS-1 clocks.
- The tick drives a selectable LED pattern across NUM_CHANNELS outputs. Patterns are: demux one toggling LED to a selected channel, rotating chase with direction control, all-toggle, or off.
- Sits between board switches and LED pins; replaces the fixed 1-to-4 demux and counter/LFSR pair.

Parameters:
- NUM_CHANNELS, 4, number of LED outputs; legal range 2..16.
- NUM_LFSR_BITS, 22, LFSR length; tick period is 2^NUM_LFSR_BITS-1 clocks; legal range 3..24.
- SEL_WIDTH, 2, width of i_Sel; must be >= clog2(NUM_CHANNELS).

Ports:
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  1 = LFSR advances; 0 = LFSR frozen, no ticks.
- i_Mode  in  2  0 = DEMUX, 1 = CHASE, 2 = ALL, 3 = OFF.
- i_Sel  in  SEL_WIDTH  channel index used in DEMUX mode.
- i_Dir  in  1  CHASE direction: 0 = up (index+1), 1 = down.
- o_LED  out  NUM_CHANNELS  registered LED drive.
- o_Tick  out  1  registered one-cycle pulse per LFSR period.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is synchronous and active-high on i_Reset. Reset overrides every other input.
- Reset values: LFSR = all zeros; r_Toggle = 0; chase position = 0 (one-hot bit 0); o_LED = 0; o_Tick = 0.
- LFSR shift and feedback: Fibonacci, shift-left. New bit 0 = XNOR of the tap bits from the XAPP052 maximal-length table for NUM_LFSR_BITS. Example for 4 bits: taps at bits 3 and 2 (0-indexed).
- LFSR cycle: all-zeros is the start state; the all-ones state is never reached.
- Tick generation:
  - When the LFSR is enabled and its next state equals all zeros, o_Tick is registered high for exactly one cycle.
  - The first tick is on edge 2^N-1 after reset is released (the first edge with i_Reset low is edge 1). Ticks then repeat every 2^N-1 edges.
- i_Enable low: LFSR holds its value and o_Tick = 0. Resuming continues from the held state, so the period is stretched by the number of disabled cycles.
- Pattern state update on each tick:
  - r_Toggle inverts.
  - Chase position changes by +1 (i_Dir = 0) or -1 (i_Dir = 1) modulo NUM_CHANNELS. Up wraps NUM_CHANNELS-1 -> 0; down wraps 0 -> NUM_CHANNELS-1.
  - Both update on every tick regardless of mode.
- Output mapping: o_LED is registered from the current i_Mode, i_Sel and the post-update pattern state on the same edge. Latency from an input change to o_LED is 1 cycle.
  - DEMUX: o_LED[i_Sel] = r_Toggle(next); all other bits 0. If i_Sel >= NUM_CHANNELS, all bits are 0.
  - CHASE: o_LED = one-hot of chase position(next).
  - ALL: every bit = r_Toggle(next).
  - OFF: o_LED = 0; LFSR, toggle and position keep running.
- Mode or select change: does not reset r_Toggle or chase position; the new mapping applies on the next edge.
- Simultaneous tick and mode/select change on one edge: o_LED uses the new mode/select and the updated state.
- i_Dir change: affects only the next position step; no immediate output change in CHASE.
- Reset mid-operation: all state returns to reset values on that edge. The first tick after release again takes 2^N-1 edges.
- Inputs are assumed already synchronised/debounced upstream.

Test Plan:
- Period/reset: NUM_LFSR_BITS=4, NUM_CHANNELS=4, i_Enable=1. Release reset -> o_Tick high for 1 cycle on edges 15, 30, 45. The LFSR visits 15 distinct states and never 1111.
- DEMUX: i_Mode=0, i_Sel=2. After the first tick, o_LED=0100; after the second, 0000; after the third, 0100. Change i_Sel to 1 while toggle=1 -> o_LED=0010 one cycle later.
- CHASE with wrap: i_Mode=1, i_Dir=0. From reset o_LED=0001, then per tick 0010, 0100, 1000, 0001. Set i_Dir=1 with position 0 -> next tick 1000.
- ALL, OFF and enable: i_Mode=2 -> o_LED alternates 1111/0000 per tick. Switch to OFF -> 0000, then back to ALL after one tick -> the phase reflects toggles that occurred during OFF. i_Enable=0 for 5 cycles -> the next tick is delayed by exactly 5 cycles.
- Boundaries: NUM_CHANNELS=3, SEL_WIDTH=2, i_Mode=0, i_Sel=3 -> o_LED=000 always. Tick coincident with a mode change 0->1 -> the output shows the advanced chase one-hot on that edge.
- Reset mid-run: assert i_Reset for 1 cycle at edge 20 -> o_LED=0, position=0001, o_Tick=0. The next tick is 15 edges after release.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives NUM_CHANNELS LED pins with a slow, selectable pattern. A
//   maximal-length XNOR LFSR acts as the prescaler. It emits a one-cycle tick
//   each time it wraps back to all-zeros, which happens every
//   2^NUM_LFSR_BITS-1 enabled clocks. Every tick flips a toggle bit and steps
//   a chase position. Those two values are then mapped onto the LEDs
//   according to the selected mode.
//
// Ports
//   i_Clk     system clock, rising edge
//   i_Reset   synchronous active-high reset
//   i_Enable  1 = prescaler advances, 0 = prescaler frozen (no ticks)
//   i_Mode    0 DEMUX, 1 CHASE, 2 ALL, 3 OFF
//   i_Sel     channel driven in DEMUX mode (out-of-range -> all off)
//   i_Dir     chase direction, 0 = up, 1 = down
//   o_LED     registered LED drive
//   o_Tick    registered one-cycle pulse per prescaler period
module led_pattern_sequencer #(
   parameter int unsigned NUM_CHANNELS  = 4,
   parameter int unsigned NUM_LFSR_BITS = 22,
   parameter int unsigned SEL_WIDTH     = 2
) (
   input  logic                    i_Clk,
   input  logic                    i_Reset,
   input  logic                    i_Enable,
   input  logic [1:0]              i_Mode,
   input  logic [SEL_WIDTH-1:0]    i_Sel,
   input  logic                    i_Dir,
   output logic [NUM_CHANNELS-1:0] o_LED,
   output logic                    o_Tick
);

   localparam int unsigned PW = $clog2(NUM_CHANNELS);

   typedef enum logic [1:0] {
      MODE_DEMUX = 2'd0,
      MODE_CHASE = 2'd1,
      MODE_ALL   = 2'd2,
      MODE_OFF   = 2'd3
   } mode_e;

   // Maximal-length tap positions (0-indexed) for an XNOR Fibonacci LFSR.
   function automatic logic [NUM_LFSR_BITS-1:0] tap_mask();
      logic [23:0] m;
      case (NUM_LFSR_BITS)
         3:       m = 24'h000006;
         4:       m = 24'h00000C;
         5:       m = 24'h000014;
         6:       m = 24'h000030;
         7:       m = 24'h000060;
         8:       m = 24'h0000B8;
         9:       m = 24'h000110;
         10:      m = 24'h000240;
         11:      m = 24'h000500;
         12:      m = 24'h000829;
         13:      m = 24'h00100D;
         14:      m = 24'h002015;
         15:      m = 24'h006000;
         16:      m = 24'h00D008;
         17:      m = 24'h012000;
         18:      m = 24'h020400;
         19:      m = 24'h040023;
         20:      m = 24'h090000;
         21:      m = 24'h140000;
         22:      m = 24'h300000;
         23:      m = 24'h420000;
         24:      m = 24'hE10000;
         default: m = '0;
      endcase
      return m[NUM_LFSR_BITS-1:0];
   endfunction

   localparam logic [NUM_LFSR_BITS-1:0] TAPS = tap_mask();

   logic [NUM_LFSR_BITS-1:0] lfsr_q, lfsr_d, lfsr_shift;
   logic                     tick_q, tick_d;
   logic                     toggle_q, toggle_d;
   logic [PW-1:0]            pos_q, pos_d;
   logic [NUM_CHANNELS-1:0]  led_q, led_d;
   mode_e                    mode;

   assign mode = mode_e'(i_Mode);

   // Every tap set has an even number of taps. A chained XNOR over them
   // therefore reduces to the XNOR-reduction of the masked state. All-ones
   // is the lock-up state, and the sequence starts from all-zeros.
   assign lfsr_shift = {lfsr_q[NUM_LFSR_BITS-2:0], ~^(lfsr_q & TAPS)};

   always_comb begin
      lfsr_d   = lfsr_q;
      tick_d   = 1'b0;
      toggle_d = toggle_q;
      pos_d    = pos_q;
      led_d    = '0;

      if (i_Enable) begin
         lfsr_d = lfsr_shift;
         tick_d = (lfsr_shift == '0);
      end

      if (tick_d) begin
         toggle_d = ~toggle_q;
         if (i_Dir) begin
            pos_d = (pos_q == '0) ? PW'(NUM_CHANNELS - 1) : pos_q - PW'(1);
         end else begin
            pos_d = (pos_q == PW'(NUM_CHANNELS - 1)) ? '0 : pos_q + PW'(1);
         end
      end

      // The output uses the post-update pattern state. This lets a tick and
      // a mode change on the same edge both show up immediately.
      case (mode)
         MODE_DEMUX: begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
               if (i_Sel == SEL_WIDTH'(i)) led_d[i] = toggle_d;
            end
         end
         MODE_CHASE: begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
               led_d[i] = (pos_d == PW'(i));
            end
         end
         MODE_ALL: led_d = {NUM_CHANNELS{toggle_d}};
         default:  led_d = '0;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         lfsr_q   <= '0;
         tick_q   <= 1'b0;
         toggle_q <= 1'b0;
         pos_q    <= '0;
         led_q    <= '0;
      end else begin
         lfsr_q   <= lfsr_d;
         tick_q   <= tick_d;
         toggle_q <= toggle_d;
         pos_q    <= pos_d;
         led_q    <= led_d;
      end
   end

   assign o_LED  = led_q;
   assign o_Tick = tick_q;

endmodule
